harmonic_envelope: RTL and testbench

Applies an ADSR amplitude envelope to the summed harmonic sample stream before it reaches the codec output stage. It consumes the harmonic sample and its ready strobe and tracks note boundaries from the note player. It scales each accepted sample by a 9-bit gain that rises, decays, sustains and releases per sample. The goal is to remove clicks at note start and end and give notes a natural shape.

---
 rtl/envelope_pkg.sv | 27 ++
 rtl/envelope_gain_fsm.sv | 131 +++++++++++++
 rtl/harmonic_envelope.sv | 89 ++++++++
 tb/tb_harmonic_envelope.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/envelope_pkg.sv
// ============================================================================
//  Module      : envelope_pkg
//  Description : Shared types and constants for the harmonic_envelope block.
//                Holds the ADSR state encoding, the gain width and the unity
//                gain value.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package envelope_pkg;

  // Gain is unsigned 9 bits, 0..256, with 256 meaning unity.
  localparam int GAIN_W     = 9;
  localparam int GAIN_UNITY = 256;

  // 3-bit ADSR state encoding.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

endpackage : envelope_pkg

`default_nettype wire

// File: rtl/envelope_gain_fsm.sv
// ============================================================================
//  Module      : envelope_gain_fsm
//  Description : ADSR state machine and gain register. Note boundaries are
//                applied every cycle; the gain steps only on accepted samples,
//                using the rule of the state after any note transition.
//  Ports       : clk, rst_n (async active-low)
//                i_accept      - a sample is consumed this cycle
//                i_note_start  - new note pulse (wins over i_note_done)
//                i_note_done   - note end pulse
//                o_gain        - current gain, 0..256
//                o_state       - current ADSR state
//                o_env_done    - pulse when RELEASE reaches gain 0
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module envelope_gain_fsm
  import envelope_pkg::*;
#(
  parameter int ATTACK_INC    = 32,
  parameter int DECAY_DEC     = 16,
  parameter int SUSTAIN_LEVEL = 128,
  parameter int RELEASE_DEC   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_accept,
  input  logic              i_note_start,
  input  logic              i_note_done,
  output logic [GAIN_W-1:0] o_gain,
  output env_state_t        o_state,
  output logic              o_env_done
);

  // One spare bit so sums past unity can be compared without wrapping.
  localparam logic [GAIN_W:0] C_INC   = (GAIN_W+1)'(ATTACK_INC);
  localparam logic [GAIN_W:0] C_DEC   = (GAIN_W+1)'(DECAY_DEC);
  localparam logic [GAIN_W:0] C_SUS   = (GAIN_W+1)'(SUSTAIN_LEVEL);
  localparam logic [GAIN_W:0] C_REL   = (GAIN_W+1)'(RELEASE_DEC);
  localparam logic [GAIN_W:0] C_UNITY = (GAIN_W+1)'(GAIN_UNITY);

  env_state_t        r_state;
  logic [GAIN_W-1:0] r_gain;
  logic              r_env_done;

  env_state_t        w_state_tr;
  env_state_t        w_state_nxt;
  logic [GAIN_W:0]   w_gain_base;
  logic [GAIN_W:0]   w_gain_nxt;
  logic              w_env_done;

  always_comb begin
    // Note boundary transitions happen first, independent of accepts.
    w_state_tr  = r_state;
    w_gain_base = {1'b0, r_gain};
    if (i_note_start) begin
      w_state_tr = ST_ATTACK;
      if (r_state == ST_IDLE) begin
        w_gain_base = '0;
      end
    end else if (i_note_done &&
                 ((r_state == ST_ATTACK) || (r_state == ST_DECAY) ||
                  (r_state == ST_SUSTAIN))) begin
      w_state_tr = ST_RELEASE;
    end

    w_state_nxt = w_state_tr;
    w_gain_nxt  = w_gain_base;
    w_env_done  = 1'b0;

    if (i_accept) begin
      case (w_state_tr)
        ST_IDLE: begin
          w_gain_nxt = '0;
        end
        ST_ATTACK: begin
          if ((w_gain_base + C_INC) >= C_UNITY) begin
            w_gain_nxt  = C_UNITY;
            w_state_nxt = ST_DECAY;
          end else begin
            w_gain_nxt = w_gain_base + C_INC;
          end
        end
        ST_DECAY: begin
          // Compare before subtracting so the step never underflows.
          if (w_gain_base <= (C_SUS + C_DEC)) begin
            w_gain_nxt  = C_SUS;
            w_state_nxt = ST_SUSTAIN;
          end else begin
            w_gain_nxt = w_gain_base - C_DEC;
          end
        end
        ST_SUSTAIN: begin
          w_gain_nxt = w_gain_base;
        end
        ST_RELEASE: begin
          if (w_gain_base <= C_REL) begin
            w_gain_nxt  = '0;
            w_state_nxt = ST_IDLE;
            w_env_done  = 1'b1;
          end else begin
            w_gain_nxt = w_gain_base - C_REL;
          end
        end
        default: begin
          w_gain_nxt  = '0;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gain     <= '0;
      r_env_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gain     <= w_gain_nxt[GAIN_W-1:0];
      r_env_done <= w_env_done;
    end
  end

  assign o_gain     = r_gain;
  assign o_state    = r_state;
  assign o_env_done = r_env_done;

endmodule : envelope_gain_fsm

`default_nettype wire

// File: rtl/harmonic_envelope.sv
// ============================================================================
//  Module      : harmonic_envelope
//  Description : Applies an ADSR amplitude envelope to the harmonic sample
//                stream. Each accepted sample is scaled by the gain held
//                before that cycle's gain step and registered one cycle later.
//  Ports       : clk, reset (async active-low)
//                sample_in/sample_in_valid - signed input sample and strobe
//                play_enable               - global play/pause
//                note_start/note_done      - note boundary pulses
//                sample_out/sample_out_valid - enveloped sample and strobe
//                note_active               - envelope not idle
//                env_done                  - release finished pulse
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module harmonic_envelope
  import envelope_pkg::*;
#(
  parameter int ATTACK_INC    = 32,
  parameter int DECAY_DEC     = 16,
  parameter int SUSTAIN_LEVEL = 128,
  parameter int RELEASE_DEC   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] sample_in,
  input  logic               sample_in_valid,
  input  logic               play_enable,
  input  logic               note_start,
  input  logic               note_done,
  output logic signed [15:0] sample_out,
  output logic               sample_out_valid,
  output logic               note_active,
  output logic               env_done
);

  logic               w_accept;
  logic [GAIN_W-1:0]  w_gain;
  env_state_t         w_state;
  logic signed [25:0] w_product;
  logic               w_unused_bits;

  logic signed [15:0] r_sample_out;
  logic               r_sample_out_valid;

  assign w_accept = sample_in_valid && play_enable;

  envelope_gain_fsm #(
    .ATTACK_INC   (ATTACK_INC),
    .DECAY_DEC    (DECAY_DEC),
    .SUSTAIN_LEVEL(SUSTAIN_LEVEL),
    .RELEASE_DEC  (RELEASE_DEC)
  ) u_gain_fsm (
    .clk         (clk),
    .rst_n       (reset),
    .i_accept    (w_accept),
    .i_note_start(note_start),
    .i_note_done (note_done),
    .o_gain      (w_gain),
    .o_state     (w_state),
    .o_env_done  (env_done)
  );

  // Gain is zero-extended to a positive signed operand; with gain <= 256 the
  // product shifted right by 8 always fits in 16 bits, so bits [23:8] are the
  // floor-rounded result.
  assign w_product     = $signed(sample_in) * $signed({1'b0, w_gain});
  assign w_unused_bits = ^{w_product[25:24], w_product[7:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sample_out       <= '0;
      r_sample_out_valid <= 1'b0;
    end else begin
      r_sample_out_valid <= w_accept;
      if (w_accept) begin
        r_sample_out <= w_product[23:8];
      end
    end
  end

  assign sample_out       = r_sample_out;
  assign sample_out_valid = r_sample_out_valid;
  assign note_active      = (w_state != ST_IDLE);

endmodule : harmonic_envelope

`default_nettype wire

// File: tb/tb_harmonic_envelope.sv
// ============================================================================
//  Module      : tb_harmonic_envelope
//  Description : Directed self-checking bench for harmonic_envelope.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_harmonic_envelope;

  logic               clk;
  logic               reset;
  logic signed [15:0] sample_in;
  logic               sample_in_valid;
  logic               play_enable;
  logic               note_start;
  logic               note_done;
  logic signed [15:0] sample_out;
  logic               sample_out_valid;
  logic               note_active;
  logic               env_done;

  int errors = 0;
  int checks = 0;

  logic signed [15:0] obs_out;
  logic               obs_v;
  logic               obs_v_next;
  logic               obs_ed;
  logic               obs_na;

  harmonic_envelope dut (
    .clk             (clk),
    .reset           (reset),
    .sample_in       (sample_in),
    .sample_in_valid (sample_in_valid),
    .play_enable     (play_enable),
    .note_start      (note_start),
    .note_done       (note_done),
    .sample_out      (sample_out),
    .sample_out_valid(sample_out_valid),
    .note_active     (note_active),
    .env_done        (env_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One accept, observed at the negedge after the capturing posedge.
  task automatic send(input logic signed [15:0] s, input int gap);
    @(negedge clk);
    sample_in       = s;
    sample_in_valid = 1'b1;
    @(negedge clk);
    sample_in_valid = 1'b0;
    obs_out = sample_out;
    obs_v   = sample_out_valid;
    obs_ed  = env_done;
    obs_na  = note_active;
    obs_v_next = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      if (g == 0) obs_v_next = sample_out_valid;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    note_start = 1'b1;
    @(negedge clk);
    note_start = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    note_done = 1'b1;
    @(negedge clk);
    note_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic go_to_sustain();
    do_reset();
    play_enable = 1'b1;
    pulse_start();
    repeat (16) send(16'sd16000, 0);
  endtask

  task automatic test_reset();
    reset = 1'b0; sample_in = '0; sample_in_valid = 1'b0;
    play_enable = 1'b0; note_start = 1'b0; note_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sample_out !== 16'sd0 || sample_out_valid !== 1'b0 ||
        note_active !== 1'b0 || env_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: out=%0d v=%b na=%b ed=%b expected all 0",
               sample_out, sample_out_valid, note_active, env_done);
    end
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if (sample_out !== 16'sd0 || sample_out_valid !== 1'b0 ||
          note_active !== 1'b0 || env_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: out=%0d v=%b na=%b ed=%b expected all 0",
                 i, sample_out, sample_out_valid, note_active, env_done);
      end
    end
  endtask

  task automatic test_attack_decay_sustain();
    int exp_v;
    play_enable = 1'b1;
    pulse_start();
    checks++;
    if (note_active !== 1'b1) begin
      errors++;
      $display("FAIL note_active_start: got %b expected 1", note_active);
    end
    for (int i = 0; i < 9; i++) begin
      send(16'sd16000, 2);
      exp_v = i * 2000;
      checks++;
      if (obs_out !== 16'(exp_v) || obs_v !== 1'b1 || obs_v_next !== 1'b0) begin
        errors++;
        $display("FAIL attack[%0d]: out=%0d v=%b vnext=%b expected %0d v=1 vnext=0",
                 i, obs_out, obs_v, obs_v_next, exp_v);
      end
    end
    for (int i = 1; i <= 8; i++) begin
      send(16'sd16000, 2);
      exp_v = 16000 - 1000 * i;
      checks++;
      if (obs_out !== 16'(exp_v) || obs_v !== 1'b1) begin
        errors++;
        $display("FAIL decay[%0d]: out=%0d v=%b expected %0d", i, obs_out, obs_v, exp_v);
      end
    end
    for (int i = 0; i < 3; i++) begin
      send(16'sd16000, 2);
      checks++;
      if (obs_out !== 16'sd8000 || obs_ed !== 1'b0 || obs_na !== 1'b1) begin
        errors++;
        $display("FAIL sustain[%0d]: out=%0d ed=%b na=%b expected 8000 ed=0 na=1",
                 i, obs_out, obs_ed, obs_na);
      end
    end
  endtask

  task automatic test_release();
    int exp_v;
    pulse_done();
    for (int i = 0; i < 16; i++) begin
      send(16'sd16000, 2);
      exp_v = 8000 - 500 * i;
      checks++;
      if (obs_out !== 16'(exp_v) || obs_ed !== (i == 15) ||
          obs_na !== (i != 15)) begin
        errors++;
        $display("FAIL release[%0d]: out=%0d ed=%b na=%b expected %0d ed=%b na=%b",
                 i, obs_out, obs_ed, obs_na, exp_v, (i == 15), (i != 15));
      end
    end
    for (int i = 0; i < 2; i++) begin
      send(16'sd16000, 2);
      checks++;
      if (obs_out !== 16'sd0 || obs_v !== 1'b1 || obs_ed !== 1'b0 || obs_na !== 1'b0) begin
        errors++;
        $display("FAIL idle_out[%0d]: out=%0d v=%b ed=%b na=%b expected 0 v=1 ed=0 na=0",
                 i, obs_out, obs_v, obs_ed, obs_na);
      end
    end
  endtask

  task automatic test_pause();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      send(16'sd16000, 2);
      checks++;
      if (obs_out !== 16'(i * 2000)) begin
        errors++;
        $display("FAIL pause_pre[%0d]: out=%0d expected %0d", i, obs_out, i * 2000);
      end
    end
    play_enable = 1'b0;
    sample_in   = 16'sd16000;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      sample_in_valid = i[0];
      checks++;
      if (sample_out_valid !== 1'b0 || sample_out !== 16'sd4000) begin
        errors++;
        $display("FAIL paused[%0d]: out=%0d v=%b expected 4000 v=0",
                 i, sample_out, sample_out_valid);
      end
    end
    @(negedge clk);
    sample_in_valid = 1'b0;
    play_enable     = 1'b1;
    send(16'sd16000, 2);
    checks++;
    if (obs_out !== 16'sd6000 || obs_v !== 1'b1) begin
      errors++;
      $display("FAIL pause_resume: out=%0d v=%b expected 6000", obs_out, obs_v);
    end
  endtask

  task automatic test_retrigger();
    // ATTACK at gain 128 -> RELEASE down to 64.
    pulse_done();
    for (int i = 0; i < 8; i++) begin
      send(16'sd16000, 1);
      checks++;
      if (obs_out !== 16'(8000 - 500 * i)) begin
        errors++;
        $display("FAIL rel_to64[%0d]: out=%0d expected %0d", i, obs_out, 8000 - 500 * i);
      end
    end
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      send(16'sd16000, 1);
      checks++;
      if (obs_out !== 16'(4000 + 2000 * i) || obs_na !== 1'b1) begin
        errors++;
        $display("FAIL retrig[%0d]: out=%0d na=%b expected %0d", i, obs_out, obs_na,
                 4000 + 2000 * i);
      end
    end
    // Gain 160 ATTACK: 11 accepts lead to SUSTAIN at 128.
    repeat (11) send(16'sd16000, 0);
    send(16'sd16000, 0);
    checks++;
    if (obs_out !== 16'sd8000) begin
      errors++;
      $display("FAIL retrig_sustain: out=%0d expected 8000", obs_out);
    end
    @(negedge clk);
    note_start = 1'b1;
    note_done  = 1'b1;
    @(negedge clk);
    note_start = 1'b0;
    note_done  = 1'b0;
    send(16'sd16000, 0);
    send(16'sd16000, 0);
    checks++;
    if (obs_out !== 16'sd10000) begin
      errors++;
      $display("FAIL start_done_same: out=%0d expected 10000", obs_out);
    end
  endtask

  task automatic test_back_to_back();
    go_to_sustain();
    @(negedge clk);
    sample_in = 16'sd256; sample_in_valid = 1'b1;
    @(negedge clk);
    sample_in = 16'sd512;
    checks++;
    if (sample_out !== 16'sd128 || sample_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_0: out=%0d v=%b expected 128", sample_out, sample_out_valid);
    end
    @(negedge clk);
    sample_in = -16'sd3;
    checks++;
    if (sample_out !== 16'sd256 || sample_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_1: out=%0d v=%b expected 256", sample_out, sample_out_valid);
    end
    @(negedge clk);
    sample_in_valid = 1'b0;
    checks++;
    if (sample_out !== -16'sd2 || sample_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_floor: out=%0d v=%b expected -2", sample_out, sample_out_valid);
    end
    @(negedge clk);
    checks++;
    if (sample_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: v=%b expected 0", sample_out_valid);
    end
    // note_done with an accept: product uses 128, step uses RELEASE rule.
    @(negedge clk);
    sample_in = 16'sd16000; sample_in_valid = 1'b1; note_done = 1'b1;
    @(negedge clk);
    sample_in_valid = 1'b0; note_done = 1'b0;
    checks++;
    if (sample_out !== 16'sd8000) begin
      errors++;
      $display("FAIL done_accept: out=%0d expected 8000", sample_out);
    end
    send(16'sd16000, 0);
    checks++;
    if (obs_out !== 16'sd7500) begin
      errors++;
      $display("FAIL done_accept_next: out=%0d expected 7500", obs_out);
    end
    // note_start with an accept in RELEASE at 112: ATTACK step to 144.
    @(negedge clk);
    sample_in = 16'sd16000; sample_in_valid = 1'b1; note_start = 1'b1;
    @(negedge clk);
    sample_in_valid = 1'b0; note_start = 1'b0;
    checks++;
    if (sample_out !== 16'sd7000) begin
      errors++;
      $display("FAIL start_accept: out=%0d expected 7000", sample_out);
    end
    send(16'sd16000, 0);
    checks++;
    if (obs_out !== 16'sd9000) begin
      errors++;
      $display("FAIL start_accept_next: out=%0d expected 9000", obs_out);
    end
  endtask

  task automatic test_arith();
    do_reset();
    pulse_start();
    repeat (8) send(16'sd16000, 0);
    send(-16'sd32768, 0);
    checks++;
    if (obs_out !== -16'sd32768) begin
      errors++;
      $display("FAIL min_unity: out=%0d expected -32768", obs_out);
    end
    pulse_start();
    send(16'sd16000, 0);
    checks++;
    if (obs_out !== 16'sd15000) begin
      errors++;
      $display("FAIL decay_retrig: out=%0d expected 15000", obs_out);
    end
    send(16'sd32767, 0);
    checks++;
    if (obs_out !== 16'sd32767) begin
      errors++;
      $display("FAIL max_unity: out=%0d expected 32767", obs_out);
    end
    repeat (7) send(16'sd0, 0);
    send(-16'sd1, 0);
    checks++;
    if (obs_out !== -16'sd1) begin
      errors++;
      $display("FAIL neg1_half: out=%0d expected -1", obs_out);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse_start();
    send(16'sd16000, 0);
    send(16'sd16000, 0);
    checks++;
    if (obs_out !== 16'sd2000 || obs_v !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: out=%0d v=%b expected 2000 v=1", obs_out, obs_v);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (sample_out !== 16'sd0 || sample_out_valid !== 1'b0 ||
        note_active !== 1'b0 || env_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: out=%0d v=%b na=%b ed=%b expected all 0",
               sample_out, sample_out_valid, note_active, env_done);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_attack_decay_sustain();
    test_release();
    test_pause();
    test_retrigger();
    test_back_to_back();
    test_arith();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_harmonic_envelope

`default_nettype wire
